// File: rtl/cond_unit.sv
// Conditional-execution unit: owns the NZCV flag register, evaluates condition
// codes against it, and issues condition-gated strobes one cycle later.
module cond_unit #(
    parameter logic [3:0] FLAG_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_write,
    input  logic       pc_src_req,
    input  logic       reg_write_req,
    input  logic       mem_write_req,
    output logic [3:0] flags,
    output logic       out_valid,
    output logic       cond_ex,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_write
);

    // Valid-only pipeline, no backpressure: an instruction is taken on every edge
    // where in_valid = 1, and out_valid marks its result bundle on the next cycle.
    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_ok;
    logic take;

    assign flag_n = flags[3];
    assign flag_z = flags[2];
    assign flag_c = flags[1];
    assign flag_v = flags[0];

    // Evaluated on the stored flags only; this instruction's ALU flags land after the edge.
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'b0000: cond_ok = flag_z;
            4'b0001: cond_ok = !flag_z;
            4'b0010: cond_ok = flag_c;
            4'b0011: cond_ok = !flag_c;
            4'b0100: cond_ok = flag_n;
            4'b0101: cond_ok = !flag_n;
            4'b0110: cond_ok = flag_v;
            4'b0111: cond_ok = !flag_v;
            4'b1000: cond_ok = flag_c && !flag_z;
            4'b1001: cond_ok = !flag_c || flag_z;
            4'b1010: cond_ok = (flag_n == flag_v);
            4'b1011: cond_ok = (flag_n != flag_v);
            4'b1100: cond_ok = !flag_z && (flag_n == flag_v);
            4'b1101: cond_ok = flag_z || (flag_n != flag_v);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    assign take = in_valid && cond_ok;

    always_ff @(posedge clk) begin
        if (!rst) begin
            flags     <= FLAG_RST;
            out_valid <= 1'b0;
            cond_ex   <= 1'b0;
            pc_src    <= 1'b0;
            reg_write <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            out_valid <= in_valid;
            cond_ex   <= take;
            pc_src    <= take && pc_src_req;
            reg_write <= take && reg_write_req;
            mem_write <= take && mem_write_req;
            // Each half of the mask is independent so partial writes merge with held bits.
            if (take && flag_write[1]) begin
                flags[3:2] <= alu_flags[3:2];
            end
            if (take && flag_write[0]) begin
                flags[1:0] <= alu_flags[1:0];
            end
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit: each step drives one cycle of inputs and checks
// the registered bundle {out_valid, cond_ex, pc_src, reg_write, mem_write, flags}.
module tb_cond_unit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic [1:0] flag_write;
    logic       pc_src_req;
    logic       reg_write_req;
    logic       mem_write_req;
    logic [3:0] flags;
    logic       out_valid;
    logic       cond_ex;
    logic       pc_src;
    logic       reg_write;
    logic       mem_write;

    int checks = 0;
    int failures = 0;
    logic [8:0] exp_q[$];
    logic [15:0] sweep_exp;

    cond_unit #(.FLAG_RST(4'b0000)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .cond(cond),
        .alu_flags(alu_flags),
        .flag_write(flag_write),
        .pc_src_req(pc_src_req),
        .reg_write_req(reg_write_req),
        .mem_write_req(mem_write_req),
        .flags(flags),
        .out_valid(out_valid),
        .cond_ex(cond_ex),
        .pc_src(pc_src),
        .reg_write(reg_write),
        .mem_write(mem_write)
    );

    // Clock and idle reset-level inputs
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // Driver: applies one cycle of inputs away from the edge and queues the expected bundle.
    task automatic drive(input logic rst_v, input logic v, input logic [3:0] c,
                         input logic [3:0] af, input logic [1:0] fw,
                         input logic pr, input logic rr, input logic mr,
                         input logic [8:0] exp_bundle);
        @(negedge clk);
        rst           = rst_v;
        in_valid      = v;
        cond          = c;
        alu_flags     = af;
        flag_write    = fw;
        pc_src_req    = pr;
        reg_write_req = rr;
        mem_write_req = mr;
        exp_q.push_back(exp_bundle);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compares the DUT bundle against the oldest queued expectation.
    task automatic check(input string tag);
        logic [8:0] obs;
        logic [8:0] exp_v;
        obs = {out_valid, cond_ex, pc_src, reg_write, mem_write, flags};
        if (exp_q.size() == 0) begin
            failures++;
            checks++;
            $error("FAIL %s: no expected value queued, observed=%b", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            checks++;
            assert (obs === exp_v) else begin
                failures++;
                $error("FAIL %s: observed=%b expected=%b (ov,ce,pc,rw,mw,nzcv)", tag, obs, exp_v);
            end
        end
    endtask

    task automatic step(input string tag, input logic rst_v, input logic v, input logic [3:0] c,
                        input logic [3:0] af, input logic [1:0] fw,
                        input logic pr, input logic rr, input logic mr,
                        input logic [8:0] exp_bundle);
        drive(rst_v, v, c, af, fw, pr, rr, mr, exp_bundle);
        check(tag);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; cond = 4'b0; alu_flags = 4'b0; flag_write = 2'b0;
        pc_src_req = 1'b0; reg_write_req = 1'b0; mem_write_req = 1'b0;
        // Expected codes for flags 1001 (N,V), bit i = code i
        sweep_exp = 16'h565A;

        step("reset",        1'b0, 1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 9'b00000_0000);
        step("al_write",     1'b1, 1'b1, 4'b1110, 4'b0110, 2'b11, 1'b0, 1'b1, 1'b0, 9'b11010_0110);
        step("set_z",        1'b1, 1'b1, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 9'b11000_0100);
        step("ne_fail",      1'b1, 1'b1, 4'b0001, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b1, 9'b10000_0100);
        step("clear",        1'b1, 1'b1, 4'b1110, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 9'b11000_0000);
        step("partial_nz",   1'b1, 1'b1, 4'b1110, 4'b1111, 2'b10, 1'b0, 1'b0, 1'b0, 9'b11000_1100);
        step("partial_cv",   1'b1, 1'b1, 4'b1110, 4'b0010, 2'b01, 1'b0, 1'b0, 1'b0, 9'b11000_1110);
        step("hi_merged",    1'b1, 1'b1, 4'b1000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 9'b10000_1110);
        step("set_nv",       1'b1, 1'b1, 4'b1110, 4'b1001, 2'b11, 1'b0, 1'b0, 1'b0, 9'b11000_1001);

        for (int i = 0; i < 16; i++) begin
            logic t;
            t = sweep_exp[i];
            step($sformatf("sweep_%0d", i), 1'b1, 1'b1, 4'(i), 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1,
                 {1'b1, t, t, t, t, 4'b1001});
        end

        step("idle_hold",    1'b1, 1'b0, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 9'b00000_1001);
        step("b2b_write",    1'b1, 1'b1, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 9'b11000_0100);
        step("b2b_eq",       1'b1, 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 9'b11010_0100);
        step("own_flags_ls", 1'b1, 1'b1, 4'b1001, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 9'b11000_0000);
        step("after_ls_eq",  1'b1, 1'b1, 4'b0000, 4'b0100, 2'b11, 1'b1, 1'b0, 1'b0, 9'b10000_0000);
        step("set_all",      1'b1, 1'b1, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 9'b11000_1111);
        step("rst_dominates",1'b0, 1'b1, 4'b1110, 4'b0110, 2'b11, 1'b1, 1'b1, 1'b1, 9'b00000_0000);
        step("post_rst_eq",  1'b1, 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 9'b10000_0000);
        step("post_rst_pc",  1'b1, 1'b1, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 9'b11100_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
# cond_unit

Conditional-execution unit for the processor datapath, and the consumer of the ALU's 4-bit NZCV flag output. It holds the architectural flag register, evaluates each instruction's 4-bit condition field against the stored flags, and updates the flags from the ALU under control of a split flag-write mask. Write-enable and branch strobes are gated by the condition result and issued as a registered, one-cycle-latency bundle to the register file, memory and PC logic.

## Interface
Parameters:
- FLAG_RST, 4'b0000, reset value of the flag register (NZCV, N = bit 3, V = bit 0)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  instruction strobe; only cycles with in_valid = 1 are evaluated
- cond  in  4  condition field of the instruction
- alu_flags  in  4  NZCV from the ALU for this instruction
- flag_write  in  2  bit1 = write N,Z; bit0 = write C,V
- pc_src_req  in  1  requested PC redirect
- reg_write_req  in  1  requested register-file write
- mem_write_req  in  1  requested memory write
- flags  out  4  current flag register
- out_valid  out  1  registered copy of in_valid
- cond_ex  out  1  registered condition result for the instruction in flight
- pc_src  out  1  pc_src_req & cond_ex, registered
- reg_write  out  1  reg_write_req & cond_ex, registered
- mem_write  out  1  mem_write_req & cond_ex, registered

## Operation
- Condition evaluation is combinational on the current flag register, never on alu_flags:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 reserved 0 (never)
- Flag update requires in_valid & cond_ex_comb. When that holds:
  - flag_write[1] loads N,Z from alu_flags[3:2].
  - flag_write[0] loads C,V from alu_flags[1:0].
  - Bits that are not enabled hold their value.
- A failed condition suppresses every side effect: no flag write and no strobe.
- When in_valid = 0, flags hold, out_valid = 0, and cond_ex and all three strobes are 0 on the next cycle.
- No state machine beyond the flag register and the output pipeline register.

## Timing
- Reset (rst = 0 at an edge):
  - flags = FLAG_RST.
  - out_valid, cond_ex, pc_src, reg_write and mem_write = 0.
  - Reset dominates in_valid in the same cycle, so an instruction presented during reset is dropped.
- Latency is 1 cycle. An instruction accepted at edge k has its outputs visible after edge k and its flag update visible after edge k.
- Back-to-back: instruction i+1 (at edge k+1) evaluates against the flags written by instruction i. This matches the ALU, which produces flags in the same cycle as the instruction.
- Same-instruction flags never affect that instruction's own condition.
- A partial write (01 or 10) followed immediately by a condition mixing both halves (e.g. HI) must use the merged register value.
- Reset mid-stream clears state; the first valid instruction after reset sees FLAG_RST.

## Test plan
- Reset, then apply in_valid = 1, cond = 1110, alu_flags = 0110, flag_write = 11, reg_write_req = 1.
  - Required next cycle: flags = 0110, cond_ex = 1, reg_write = 1.
- Set flags = 0100 (Z), then apply cond = 0001 (NE), flag_write = 11, alu_flags = 1000, mem_write_req = 1.
  - Required: cond_ex = 0, mem_write = 0, flags stay 0100.
- From flags = 0000, apply flag_write = 10 with alu_flags = 1111, then flag_write = 01 with alu_flags = 0010.
  - Required: flags = 1100, then 1110.
  - Then apply cond = 1000 (HI). Required: cond_ex = 0, because Z = 1.
- Sweep all 16 cond codes against flags 1001 (N, V).
  - Required: GE = 1, LT = 0, GT = 1, LE = 0, MI = 1, VS = 1, 1111 = 0.
- Hold in_valid = 0 with flag_write = 11 and alu_flags = 1111.
  - Required: flags unchanged, out_valid = 0, all strobes 0.
- Assert rst = 0 in the same cycle as a valid AL pc_src_req.
  - Required: pc_src = 0 and flags = FLAG_RST on the next cycle.
